ram_port_arbiter: RTL and testbench

- Shares the single DDR3 `ram` controller port between the core's instruction-fetch port (read-only) and data port (read/write).
- Sits between the RISC-V core and `ram`.
- Runs one transaction at a time, with round-robin arbitration, a read-return timeout and spurious-response detection.
- Owns the `ram` read_req/write_req handshake so neither core port sees DDR3 latency rules.

---
 rtl/ram_port_arbiter_pkg.sv | 20 ++
 rtl/ram_port_arbiter_if.sv | 59 +++++
 rtl/ram_port_arbiter_rr_pick2.sv | 23 ++
 rtl/ram_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the instruction/data port arbiter in front of the DDR3 ram controller.
// Holds the FSM state, port-owner encoding and the timeout counter sizing helper.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD
    } state_t;

    typedef enum logic {
        INSTR,
        DATA
    } owner_t;

    function automatic int cnt_w(input int tc);
        return (tc < 2) ? 1 : $clog2(tc);
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of the core-side ports, the ram-side handshake and arbiter status flags.
// slave is the arbiter view; master is the view of whatever drives and observes it.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_read_req;
    logic              ram_write_req;
    logic              ram_read_ready;
    logic              ram_write_ready;
    logic              ram_read_data_valid;
    logic [DATA_W-1:0] ram_read_data;

    logic              busy;
    logic              timeout;
    logic              spurious;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  ram_read_ready, ram_write_ready,
        input  ram_read_data_valid, ram_read_data,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output ram_addr, ram_wdata,
        output ram_read_req, ram_write_req,
        output busy, timeout, spurious
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output ram_read_ready, ram_write_ready,
        output ram_read_data_valid, ram_read_data,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_addr, ram_wdata,
        input  ram_read_req, ram_write_req,
        input  busy, timeout, spurious
    );

endinterface

// File: rtl/ram_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins, on a tie the port
// that did not own the previous transaction wins.
module rr_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     last_i,
    output owner_t     win_o,
    output logic       any_o
);

    assign any_o = |req_i;

    always_comb begin
        win_o = INSTR;
        unique case (1'b1)
            req_i == 2'b11: win_o = (last_i == INSTR) ? DATA : INSTR;
            req_i == 2'b10: win_o = DATA;
            default:        win_o = INSTR;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one DDR3 ram port between instruction fetch and data access,
// one transaction at a time, with read timeout and spurious-return flagging.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input logic                CLK,
    input logic                RSTn,
    ram_port_arbiter_if.slave  bus
);

    localparam int            CW   = cnt_w(TIMEOUT_CYC);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYC - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_rvalid_q, i_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic              tmo_q, tmo_d;
    logic              spur_q, spur_d;

    owner_t win;
    logic   any;
    logic   rd_req;
    logic   wr_req;
    logic   accept;

    rr_pick2 u_pick (
        .req_i  ({bus.d_req, bus.i_req}),
        .last_i (last_q),
        .win_o  (win),
        .any_o  (any)
    );

    assign rd_req = (state_q == ISSUE) & ~we_q;
    assign wr_req = (state_q == ISSUE) &  we_q;
    assign accept = (rd_req & bus.ram_read_ready)
                  | (wr_req & bus.ram_write_ready);

    // Grant is combinational so the requester sees it in the accepting cycle.
    assign bus.i_gnt         = accept & (owner_q == INSTR);
    assign bus.d_gnt         = accept & (owner_q == DATA);
    assign bus.ram_read_req  = rd_req;
    assign bus.ram_write_req = wr_req;
    assign bus.ram_addr      = addr_q;
    assign bus.ram_wdata     = wdata_q;
    assign bus.i_rvalid      = i_rvalid_q;
    assign bus.i_rdata       = i_rdata_q;
    assign bus.d_rvalid      = d_rvalid_q;
    assign bus.d_rdata       = d_rdata_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.timeout       = tmo_q;
    assign bus.spurious      = spur_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        tmo_d      = 1'b0;
        spur_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                spur_d = bus.ram_read_data_valid;
                if (any) begin
                    owner_d = win;
                    last_d  = win;
                    we_d    = (win == DATA) & bus.d_we;
                    addr_d  = (win == DATA) ? bus.d_addr : bus.i_addr;
                    wdata_d = (win == DATA) ? bus.d_wdata : '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                spur_d = bus.ram_read_data_valid;
                if (accept) begin
                    if (we_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                cnt_d = cnt_q + 1'b1;
                // Returned data beats the timeout when both land together.
                if (bus.ram_read_data_valid) begin
                    if (owner_q == DATA) begin
                        d_rdata_d  = bus.ram_read_data;
                        d_rvalid_d = 1'b1;
                    end else begin
                        i_rdata_d  = bus.ram_read_data;
                        i_rvalid_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (cnt_q == TERM) begin
                    tmo_d = 1'b1;
                    if (owner_q == DATA) begin
                        d_rdata_d  = '0;
                        d_rvalid_d = 1'b1;
                    end else begin
                        i_rdata_d  = '0;
                        i_rvalid_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            owner_q    <= INSTR;
            last_q     <= INSTR;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            tmo_q      <= 1'b0;
            spur_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            tmo_q      <= tmo_d;
            spur_q     <= spur_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scenario bench for ram_port_arbiter: per-feature tasks plus a read-return
// scoreboard that pairs every rvalid pulse with the owner and data expected.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    typedef struct packed {
        owner_t      own;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];

    logic [31:0]  exp_i_rdata;
    logic [31:0]  exp_d_rdata;
    logic [136:0] outs;

    ram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ram_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus.slave)
    );

    assign outs = {bus.i_gnt, bus.i_rvalid, bus.i_rdata,
                   bus.d_gnt, bus.d_rvalid, bus.d_rdata,
                   bus.ram_addr, bus.ram_wdata,
                   bus.ram_read_req, bus.ram_write_req,
                   bus.busy, bus.timeout, bus.spurious};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    always @(negedge clk) begin
        if (rst_n && (bus.i_rvalid || bus.d_rvalid)) begin
            exp_t e;
            owner_t got;
            logic [31:0] gd;
            checks++;
            got = bus.d_rvalid ? DATA : INSTR;
            gd  = bus.d_rvalid ? bus.d_rdata : bus.i_rdata;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected: owner=%0d data=%h, required no rvalid",
                         got, gd);
            end else begin
                e = sb.pop_front();
                if ((bus.i_rvalid && bus.d_rvalid) || got !== e.own || gd !== e.data) begin
                    errors++;
                    $display("FAIL rvalid_data: i_rv=%0b d_rv=%0b owner=%0d data=%h, required owner=%0d data=%h",
                             bus.i_rvalid, bus.d_rvalid, got, gd, e.own, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%0b, required 0", bus.busy);
        end
    endtask

    task automatic test_instr_read();
        tick();
        bus.i_req          = 1'b1;
        bus.i_addr         = 32'h0000_0100;
        bus.ram_read_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.i_gnt !== 1'b0) begin
            errors++;
            $display("FAIL ird_gnt_c0: i_gnt=%0b, required 0", bus.i_gnt);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0 || bus.ram_read_req !== 1'b1
            || bus.ram_write_req !== 1'b0 || bus.ram_addr !== 32'h0000_0100) begin
            errors++;
            $display("FAIL ird_gnt_c1: i_gnt=%0b d_gnt=%0b rreq=%0b wreq=%0b addr=%h, required 1 0 1 0 00000100",
                     bus.i_gnt, bus.d_gnt, bus.ram_read_req, bus.ram_write_req, bus.ram_addr);
        end
        tick();
        bus.i_req = 1'b0;
        repeat (3) tick();
        tick();
        bus.ram_read_data_valid = 1'b1;
        bus.ram_read_data       = 32'hA5A5_0001;
        sb.push_back('{INSTR, 32'hA5A5_0001});
        exp_i_rdata = 32'hA5A5_0001;
        tick();
        bus.ram_read_data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.i_rvalid !== 1'b1 || bus.d_rvalid !== 1'b0 || bus.d_rdata !== exp_d_rdata
            || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ird_return: i_rv=%0b d_rv=%0b d_rdata=%h busy=%0b, required 1 0 %h 0",
                     bus.i_rvalid, bus.d_rvalid, bus.d_rdata, bus.busy, exp_d_rdata);
        end
    endtask

    task automatic test_data_write();
        tick();
        bus.d_req           = 1'b1;
        bus.d_we            = 1'b1;
        bus.d_addr          = 32'h0000_0200;
        bus.d_wdata         = 32'hDEAD_BEEF;
        bus.ram_read_ready  = 1'b0;
        bus.ram_write_ready = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus.ram_write_ready = (k == 4);
            @(negedge clk);
            checks++;
            if (bus.ram_write_req !== 1'b1 || bus.ram_read_req !== 1'b0
                || bus.ram_addr !== 32'h0000_0200 || bus.ram_wdata !== 32'hDEAD_BEEF
                || bus.d_gnt !== (k == 4) || bus.i_gnt !== 1'b0) begin
                errors++;
                $display("FAIL wr_issue_c%0d: wreq=%0b rreq=%0b addr=%h wdata=%h d_gnt=%0b i_gnt=%0b, required 1 0 00000200 deadbeef %0b 0",
                         k, bus.ram_write_req, bus.ram_read_req, bus.ram_addr,
                         bus.ram_wdata, bus.d_gnt, bus.i_gnt, (k == 4));
            end
        end
        tick();
        bus.d_req           = 1'b0;
        bus.d_we            = 1'b0;
        bus.ram_write_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.ram_write_req !== 1'b0 || bus.d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: busy=%0b wreq=%0b d_rv=%0b, required 0 0 0",
                     bus.busy, bus.ram_write_req, bus.d_rvalid);
        end
    endtask

    task automatic test_round_robin();
        int     n;
        int     pend;
        bit     done;
        owner_t got;
        owner_t want;
        owner_t gown;
        logic [31:0] dv;
        n    = 0;
        pend = 0;
        done = 1'b0;
        gown = INSTR;
        tick();
        rst_n = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.i_req          = 1'b1;
        bus.i_addr         = 32'h0000_1000;
        bus.d_req          = 1'b1;
        bus.d_we           = 1'b0;
        bus.d_addr         = 32'h0000_2000;
        bus.ram_read_ready = 1'b1;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clk);
            if (bus.i_gnt || bus.d_gnt) begin
                checks++;
                got  = bus.d_gnt ? DATA : INSTR;
                want = (n % 2 == 0) ? DATA : INSTR;
                if ((bus.i_gnt && bus.d_gnt) || got !== want) begin
                    errors++;
                    $display("FAIL rr_grant_%0d: i_gnt=%0b d_gnt=%0b owner=%0d, required owner=%0d",
                             n, bus.i_gnt, bus.d_gnt, got, want);
                end
                n++;
                pend = 2;
                gown = got;
            end
            tick();
            bus.ram_read_data_valid = 1'b0;
            if (n == 4) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    dv = 32'hC0DE_0000 + 32'(n);
                    bus.ram_read_data_valid = 1'b1;
                    bus.ram_read_data       = dv;
                    sb.push_back('{gown, dv});
                    if (gown == DATA) exp_d_rdata = dv;
                    else              exp_i_rdata = dv;
                end
            end else if (n == 4 && sb.size() == 0) begin
                done = 1'b1;
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.ram_read_data_valid = 1'b0;
        checks++;
        if (n != 4 || !done) begin
            errors++;
            $display("FAIL rr_count: grants=%0d done=%0b, required 4 1", n, done);
        end
    endtask

    task automatic test_timeout();
        int  n;
        bit  hit;
        n   = 0;
        hit = 1'b0;
        tick();
        bus.d_req          = 1'b1;
        bus.d_we           = 1'b0;
        bus.d_addr         = 32'h0000_0300;
        bus.ram_read_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.d_gnt !== 1'b1 || bus.ram_read_req !== 1'b1) begin
            errors++;
            $display("FAIL tmo_gnt: d_gnt=%0b rreq=%0b, required 1 1", bus.d_gnt, bus.ram_read_req);
        end
        sb.push_back('{DATA, 32'h0});
        exp_d_rdata = '0;
        for (int k = 0; k < 20 && !hit; k++) begin
            tick();
            if (k == 0) bus.d_req = 1'b0;
            @(negedge clk);
            if (bus.timeout) hit = 1'b1;
            else             n++;
        end
        checks++;
        if (!hit || n != 8 || bus.busy !== 1'b0 || bus.d_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL tmo_pulse: hit=%0b wait_cycles=%0d busy=%0b d_rv=%0b, required 1 8 0 1",
                     hit, n, bus.busy, bus.d_rvalid);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.timeout !== 1'b0 || bus.d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL tmo_after: timeout=%0b d_rdata=%h, required 0 00000000",
                     bus.timeout, bus.d_rdata);
        end
    endtask

    task automatic test_timeout_tie();
        tick();
        bus.i_req          = 1'b1;
        bus.i_addr         = 32'h0000_0500;
        bus.ram_read_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL tie_gnt: i_gnt=%0b, required 1", bus.i_gnt);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 0) bus.i_req = 1'b0;
            if (k == 7) begin
                bus.ram_read_data_valid = 1'b1;
                bus.ram_read_data       = 32'h7777_0009;
                sb.push_back('{INSTR, 32'h7777_0009});
                exp_i_rdata = 32'h7777_0009;
            end
        end
        tick();
        bus.ram_read_data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.timeout !== 1'b0 || bus.i_rvalid !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL tie_valid_wins: timeout=%0b i_rv=%0b busy=%0b, required 0 1 0",
                     bus.timeout, bus.i_rvalid, bus.busy);
        end
    endtask

    task automatic test_spurious();
        tick();
        bus.ram_read_data_valid = 1'b1;
        bus.ram_read_data       = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (bus.spurious !== 1'b0) begin
            errors++;
            $display("FAIL spur_early: spurious=%0b, required 0", bus.spurious);
        end
        tick();
        bus.ram_read_data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.spurious !== 1'b1 || bus.i_rdata !== exp_i_rdata || bus.d_rdata !== exp_d_rdata
            || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL spur_pulse: spurious=%0b i_rdata=%h d_rdata=%h busy=%0b, required 1 %h %h 0",
                     bus.spurious, bus.i_rdata, bus.d_rdata, bus.busy, exp_i_rdata, exp_d_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.spurious !== 1'b0) begin
            errors++;
            $display("FAIL spur_len: spurious=%0b, required 0", bus.spurious);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        bus.i_req          = 1'b1;
        bus.i_addr         = 32'h0000_0400;
        bus.ram_read_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (bus.i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstm_gnt: i_gnt=%0b, required 1", bus.i_gnt);
        end
        tick();
        bus.i_req = 1'b0;
        tick();
        rst_n = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        @(negedge clk);
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rstm_outputs: got %h, required 0", outs);
        end
        tick();
        rst_n = 1'b1;
        tick();
        bus.ram_read_data_valid = 1'b1;
        bus.ram_read_data       = 32'hBAD0_0001;
        tick();
        bus.ram_read_data_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.spurious !== 1'b1 || bus.i_rvalid !== 1'b0 || bus.i_rdata !== 32'h0
            || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstm_late: spurious=%0b i_rv=%0b i_rdata=%h busy=%0b, required 1 0 00000000 0",
                     bus.spurious, bus.i_rvalid, bus.i_rdata, bus.busy);
        end
    endtask

    initial begin
        checks                  = 0;
        errors                  = 0;
        exp_i_rdata             = '0;
        exp_d_rdata             = '0;
        rst_n                   = 1'b0;
        bus.i_req               = 1'b0;
        bus.i_addr              = '0;
        bus.d_req               = 1'b0;
        bus.d_we                = 1'b0;
        bus.d_addr              = '0;
        bus.d_wdata             = '0;
        bus.ram_read_ready      = 1'b0;
        bus.ram_write_ready     = 1'b0;
        bus.ram_read_data_valid = 1'b0;
        bus.ram_read_data       = '0;

        test_reset();
        test_instr_read();
        test_data_write();
        test_round_robin();
        test_timeout();
        test_timeout_tie();
        test_spurious();
        test_reset_mid();

        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d rvalid still outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
